vector_exec_unit: RTL and testbench
===================================

// Module: vector_exec_unit
//
// PURPOSE
// Multi-cycle lane-wise vector execute stage directly downstream of the 8x256b
// vector register file. Captures two source vectors (regfile data_1/data_2) plus
// a scalar at start, processes LANES_PER_CYCLE 16-bit lanes per clock, then
// issues a single-cycle write-back (wr_en/wr_dst/wr_data) into the register file.
//
// PARAMETERS
// LANE_W           16  bits per lane
// LANES            16  lanes per vector; vector width = LANES*LANE_W = 256
// LANES_PER_CYCLE   4  lanes computed per EXEC cycle; must divide LANES
//
// PORTS
// clk      in   1    clock, all state on rising edge
// rst      in   1    asynchronous, active-high reset
// start    in   1    launch op; sampled only while busy==0
// op       in   2    00 VADD, 01 VSUB (a-b), 10 VAND, 11 VSMUL (a*scalar)
// dst      in   3    destination vector register index
// src_a    in   256  operand A (regfile data_1)
// src_b    in   256  operand B (regfile data_2); unused for VSMUL
// scalar   in   16   scalar operand for VSMUL; unused otherwise
// busy     out  1    high in EXEC and WB states
// done     out  1    one-cycle pulse, coincident with wr_en
// wr_en    out  1    regfile write enable, one-cycle pulse
// wr_dst   out  3    regfile write index (latched dst)
// wr_data  out  256  result vector
//
// BEHAVIOUR
// - Reset: state=IDLE, lane counter=0, busy=0, done=0, wr_en=0, wr_dst=0,
//   wr_data=0, operand/result registers=0. Reset mid-op aborts; no write issued.
// - States: IDLE -> EXEC -> WB -> IDLE.
//   IDLE: on start=1 latch op, dst, src_a, src_b, scalar; cnt=0; go EXEC.
//   EXEC: compute lanes cnt*LPC .. cnt*LPC+LPC-1 into result register;
//         cnt increments; after group N-1 (N=LANES/LPC) go WB.
//   WB:   wr_en=1, done=1, wr_dst=latched dst, wr_data=result; go IDLE.
// - Latency: start sampled at edge 0; EXEC edges 1..N; wr_en/done high in
//   cycle N+1 (default N=4 -> write-back 5 cycles after start edge).
// - start while busy (EXEC or WB) ignored, no queueing. Back-to-back: start may
//   be accepted in the first IDLE cycle after WB.
// - Sources sampled only at start; later regfile changes (incl. the WB write
//   to a source register) do not affect an op in flight.
// - Lane k = bits [16k+15:16k]. All arithmetic modulo 2^16, no saturation,
//   no flags. VSMUL keeps low 16 bits of the 32-bit product (sign-agnostic).
// - wr_data holds last result after WB until next WB or reset; wr_dst likewise.
// - Outputs registered; no combinational path from inputs to outputs.
//
// STRUCTURE
// - Shared package vec_pkg: LANE_W, LANES, opcode localparams (OP_VADD,
//   OP_VSUB, OP_VAND, OP_VSMUL), state encoding (S_IDLE, S_EXEC, S_WB).
// - Sub-module vec_lane_alu: combinational one-lane op (op, a, b, scalar ->
//   16b result); instantiated LANES_PER_CYCLE times, inputs muxed by cnt.
// - Top: FSM, lane counter, operand/result registers, write-back outputs.
//
// TESTING
// - Reset: rst pulsed async mid-cycle -> all outputs 0 immediately; then
//   VADD started and rst asserted in EXEC -> no wr_en ever observed.
// - VADD: a lanes=0xFFFF, b lanes=0x0002, dst=5 -> 5 cycles later one-cycle
//   wr_en/done, wr_dst=5, every lane 0x0001 (wrap).
// - VSUB/VAND: a lane k=k, b lane k=0x0003 -> VSUB lane0=0xFFFD, lane15=0x000C;
//   VAND a=0xF0F0.., b=0x3C3C.. -> every lane 0x3030.
// - VSMUL: a lane k=0x1000+k, scalar=0x0010 -> lane k=(0x0000+(k<<4)),
//   i.e. 0x1000*0x10 overflow discarded, lane3=0x0030.
// - Busy ignore: start pulsed every cycle for 12 cycles -> exactly 2 writes,
//   second from op latched in first IDLE cycle after first WB; busy profile
//   matches 5-high/1-low pattern.
// - Operand capture: change src_a/src_b one cycle after start -> result
//   reflects values at start edge only.

Source files
------------

// File: rtl/vec_pkg.sv
// vec_pkg: shared lane geometry, opcodes and FSM encoding for the vector execute stage.
package vec_pkg;
  localparam int LANE_W = 16;
  localparam int LANES = 16;
  localparam int LANES_PER_CYCLE = 4;
  localparam int VEC_W = LANES * LANE_W;
  localparam int GROUPS = LANES / LANES_PER_CYCLE;
  localparam int CNT_W = GROUPS > 1 ? $clog2(GROUPS) : 1;
  localparam logic [1:0] OP_VADD = 2'b00;
  localparam logic [1:0] OP_VSUB = 2'b01;
  localparam logic [1:0] OP_VAND = 2'b10;
  localparam logic [1:0] OP_VSMUL = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;
endpackage

// File: rtl/vec_lane_alu.sv
// vec_lane_alu: combinational single-lane op, modulo 2^LANE_W.
module vec_lane_alu
  import vec_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  input  logic [LANE_W-1:0] scalar,
  output logic [LANE_W-1:0] y
);
  always_comb
    y = op == OP_VADD ? a + b :
        op == OP_VSUB ? a - b :
        op == OP_VAND ? a & b :
        op == OP_VSMUL ? a * scalar : '0;
endmodule

// File: rtl/vector_exec_unit.sv
// vector_exec_unit: multi-cycle lane-wise vector execute stage with single-cycle regfile write-back.
module vector_exec_unit
  import vec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [2:0]        dst,
  input  logic [VEC_W-1:0]  src_a,
  input  logic [VEC_W-1:0]  src_b,
  input  logic [LANE_W-1:0] scalar,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [2:0]        wr_dst,
  output logic [VEC_W-1:0]  wr_data
);
  state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0] op_q;
  logic [2:0] dst_q;
  logic [VEC_W-1:0] a_q, b_q, res, res_n;
  logic [LANE_W-1:0] s_q;
  logic [LANE_W-1:0] y [LANES_PER_CYCLE];
  logic last;
  for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
    vec_lane_alu u_alu (
      .op(op_q),
      .a(a_q[(int'(cnt) * LANES_PER_CYCLE + g) * LANE_W +: LANE_W]),
      .b(b_q[(int'(cnt) * LANES_PER_CYCLE + g) * LANE_W +: LANE_W]),
      .scalar(s_q),
      .y(y[g])
    );
  end
  always_comb begin
    last = cnt == CNT_W'(GROUPS - 1);
    state_n = state == S_IDLE ? (start ? S_EXEC : S_IDLE) :
              state == S_EXEC ? (last ? S_WB : S_EXEC) : S_IDLE;
    res_n = res;
    for (int i = 0; i < LANES_PER_CYCLE; i++)
      res_n[(int'(cnt) * LANES_PER_CYCLE + i) * LANE_W +: LANE_W] = y[i];
  end
  // wr_data/wr_dst load on the final EXEC edge so they hold steadily between write-backs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      op_q <= '0;
      dst_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      res <= '0;
      wr_dst <= '0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        op_q <= op;
        dst_q <= dst;
        a_q <= src_a;
        b_q <= src_b;
        s_q <= scalar;
        cnt <= '0;
      end
      if (state == S_EXEC) begin
        res <= res_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          wr_data <= res_n;
          wr_dst <= dst_q;
        end
      end
    end
  end
  assign busy = state != S_IDLE;
  assign wr_en = state == S_WB;
  assign done = wr_en;
endmodule

// File: tb/tb_vector_exec_unit.sv
// tb_vector_exec_unit: directed checks of vector_exec_unit ops, latency, busy ignore, operand capture and reset.
module tb_vector_exec_unit;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] op = 0;
  logic [2:0] dst = 0;
  logic [255:0] src_a = 0, src_b = 0;
  logic [15:0] scalar = 0;
  logic busy, done, wr_en;
  logic [2:0] wr_dst;
  logic [255:0] wr_data;
  int checks = 0, failures = 0;
  vector_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .dst(dst),
    .src_a(src_a), .src_b(src_b), .scalar(scalar),
    .busy(busy), .done(done), .wr_en(wr_en), .wr_dst(wr_dst), .wr_data(wr_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = v;
    return r;
  endfunction
  function automatic logic [255:0] ramp(input logic [15:0] base);
    logic [255:0] r;
    for (int k = 0; k < 16; k++) r[16*k +: 16] = base + 16'(k);
    return r;
  endfunction
  // After the start edge the inputs are scrambled, so results prove capture at start only
  task automatic run_op(input string tag, input logic [1:0] o, input logic [2:0] d,
                        input logic [255:0] a, input logic [255:0] b, input logic [15:0] s,
                        input logic [255:0] exp);
    int lat;
    @(negedge clk);
    op = o; dst = d; src_a = a; src_b = b; scalar = s; start = 1;
    @(posedge clk);
    #1 start = 0; op = ~o; dst = ~d; src_a = ~a; src_b = ~b; scalar = ~s;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wr_en && lat < 20);
    chk({tag, "_lat"}, 256'(lat), 256'd5);
    chk({tag, "_done"}, 256'(done), 256'd1);
    chk({tag, "_busy_wb"}, 256'(busy), 256'd1);
    chk({tag, "_dst"}, 256'(wr_dst), 256'(d));
    chk({tag, "_data"}, wr_data, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 256'({wr_en, done, busy}), 256'd0);
    chk({tag, "_hold"}, wr_data, exp);
  endtask
  logic [17:0] busy_seen, wr_seen;
  logic [255:0] v;
  int writes;
  initial begin
    #1 chk("rst_outs", {busy, done, wr_en, wr_dst, wr_data}, '0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("idle_outs", {busy, done, wr_en, wr_dst, wr_data}, '0);
    run_op("vadd", 2'b00, 3'd5, fill(16'hFFFF), fill(16'h0002), 16'h0, fill(16'h0001));
    v = ramp(16'h0000);
    run_op("vsub", 2'b01, 3'd3, v, fill(16'h0003), 16'h0, {16'h000C, 16'h000B, 16'h000A, 16'h0009,
      16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001,
      16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFD});
    chk("vsub_lane0", 256'(wr_data[15:0]), 256'h FFFD);
    chk("vsub_lane15", 256'(wr_data[255:240]), 256'h000C);
    run_op("vand", 2'b10, 3'd2, fill(16'hF0F0), fill(16'h3C3C), 16'h0, fill(16'h3030));
    run_op("vsmul", 2'b11, 3'd7, ramp(16'h1000), fill(16'hFFFF), 16'h0010, {16'h00F0, 16'h00E0,
      16'h00D0, 16'h00C0, 16'h00B0, 16'h00A0, 16'h0090, 16'h0080, 16'h0070, 16'h0060,
      16'h0050, 16'h0040, 16'h0030, 16'h0020, 16'h0010, 16'h0000});
    chk("vsmul_lane3", 256'(wr_data[63:48]), 256'h0030);
    // start held high for 12 cycles; only edges 0 and 6 land in IDLE
    busy_seen = 0; wr_seen = 0; writes = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      busy_seen[c] = busy;
      wr_seen[c] = wr_en;
      if (wr_en) writes++;
      if (c == 5) begin
        chk("b2b_w1_dst", 256'(wr_dst), 256'd1);
        chk("b2b_w1_data", wr_data, fill(16'h0002));
      end
      if (c == 11) begin
        chk("b2b_w2_dst", 256'(wr_dst), 256'd4);
        chk("b2b_w2_data", wr_data, fill(16'h000F));
      end
      start = c < 12;
      if (c < 6) begin op = 2'b00; dst = 3'd1; src_a = fill(16'h0001); src_b = fill(16'h0001); end
      else if (c == 6) begin op = 2'b10; dst = 3'd4; src_a = fill(16'h00FF); src_b = fill(16'h0F0F); end
      else begin op = 2'b01; dst = 3'd6; src_a = fill(16'h1234); src_b = fill(16'h0004); end
    end
    chk("b2b_writes", 256'(writes), 256'd2);
    chk("b2b_busy", 256'(busy_seen), 256'h00FBE);
    chk("b2b_wr", 256'(wr_seen), 256'h00820);
    @(posedge clk);
    #3 rst = 1;
    #1 chk("arst_outs", {busy, done, wr_en, wr_dst, wr_data}, '0);
    @(negedge clk);
    rst = 0;
    op = 2'b00; dst = 3'd5; src_a = fill(16'h0001); src_b = fill(16'h0001); start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(negedge clk);
    chk("abort_busy_pre", 256'(busy), 256'd1);
    @(posedge clk);
    #3 rst = 1;
    #1 chk("abort_busy", 256'(busy), 256'd0);
    @(negedge clk);
    rst = 0;
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wr_en) writes++;
    end
    chk("abort_writes", 256'(writes), 256'd0);
    chk("abort_data", {wr_dst, wr_data}, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
